// File: rtl/common_defs.sv
// Shared types for the RGB word packer: pixel layout, skid buffer entry and
// packing phase encoding.
package common_defs;

  localparam int unsigned PIX_BYTES = 3;

  // Packed so that b sits in the low byte, matching the output byte order.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic [31:0] tdata;
    logic        tlast;
    logic        tuser;
  } skid_entry_t;

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2,
    PH3 = 2'd3
  } phase_e;

endpackage

// File: rtl/axis_skid2.sv
// Two-entry in-order stream buffer holding {tdata, tlast, tuser}; the head
// entry drives the outputs and only changes when it is popped.
module axis_skid2
  import common_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  logic [31:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tuser,
  output logic [31:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tuser,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [1:0]  o_count
);

  skid_entry_t r_e0;
  skid_entry_t r_e1;
  skid_entry_t w_in;
  logic [1:0]  r_count;
  logic        w_pop;

  assign w_in  = '{tdata: i_tdata, tlast: i_tlast, tuser: i_tuser};
  assign w_pop = (r_count != 2'd0) && i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_e0    <= '0;
      r_e1    <= '0;
      r_count <= '0;
    end else begin
      case ({i_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_e0 <= w_in;
          else                 r_e1 <= w_in;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_e0    <= r_e1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd2) begin
            r_e0 <= r_e1;
            r_e1 <= w_in;
          end else begin
            r_e0 <= w_in;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_tdata = r_e0.tdata;
  assign o_tlast = r_e0.tlast;
  assign o_tuser = r_e0.tuser;
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/rgb_word_packer.sv
// Packs 24-bit pixels into dense 32-bit stream words (4 pixels -> 3 words).
// Optional alignment checker enabled by defining PACKER_ALIGN_CHECK_EN.
module rgb_word_packer
  import common_defs::*;
#(
  parameter int unsigned LINE_PIXELS = 640,
  parameter int unsigned SKID_DEPTH  = 2
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  input  logic        sof,
  input  logic        eol,
  input  logic        valid,
  output logic        in_ready,
  output logic [31:0] out_stream_tdata,
  output logic [3:0]  out_stream_tkeep,
  output logic        out_stream_tlast,
  output logic        out_stream_tuser,
  output logic        out_stream_tvalid,
  input  logic        out_stream_tready
`ifdef PACKER_ALIGN_CHECK_EN
  ,
  output logic        err_align
`endif
);

  if ((LINE_PIXELS % 4) != 0) begin : g_bad_line
    $error("LINE_PIXELS must be a multiple of 4");
  end
  if (SKID_DEPTH != 2) begin : g_bad_depth
    $error("SKID_DEPTH is fixed at 2");
  end

  localparam logic [1:0] SKID_FULL = 2'(SKID_DEPTH);

  phase_e                 r_ph, w_ph_nxt, w_eff_ph;
  logic [PIX_BYTES*8-1:0] r_hold, w_hold_nxt;
  logic [15:0]            r_tail, w_tail_nxt;
  logic                   r_tail_pend, w_tail_pend_nxt;
  logic                   r_sof_pend, w_sof_pend_nxt, w_sof_now;
  logic                   r_in_ready, w_in_ready_nxt;
  logic                   w_accept, w_push, w_pop;
  logic [31:0]            w_push_tdata;
  logic                   w_push_tlast;
  logic [1:0]             w_count, w_cnt_nxt;
  rgb_t                   w_px;

  assign w_px     = {r, g, b};
  assign w_accept = valid && r_in_ready;
  assign w_pop    = out_stream_tvalid && out_stream_tready;
  assign w_eff_ph = sof ? PH0 : r_ph;   // sof restarts packing, dropping held bytes

  assign w_sof_now      = r_sof_pend || (w_accept && sof);
  assign w_sof_pend_nxt = w_sof_now && !w_push;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_ph        <= PH0;
      r_hold      <= '0;
      r_tail      <= '0;
      r_tail_pend <= 1'b0;
      r_sof_pend  <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_ph        <= w_ph_nxt;
      r_hold      <= w_hold_nxt;
      r_tail      <= w_tail_nxt;
      r_tail_pend <= w_tail_pend_nxt;
      r_sof_pend  <= w_sof_pend_nxt;
      r_in_ready  <= w_in_ready_nxt;
    end
  end

  // A misaligned eol at ph1/ph2 leaves 1-2 bytes over; they go out as a
  // separate tlast word on a following cycle while input is held off.
  always_comb begin
    w_push          = 1'b0;
    w_push_tdata    = '0;
    w_push_tlast    = 1'b0;
    w_ph_nxt        = r_ph;
    w_hold_nxt      = r_hold;
    w_tail_nxt      = r_tail;
    w_tail_pend_nxt = r_tail_pend;
    if (r_tail_pend) begin
      if ((w_count != SKID_FULL) || w_pop) begin
        w_push          = 1'b1;
        w_push_tdata    = {16'h0, r_tail};
        w_push_tlast    = 1'b1;
        w_tail_pend_nxt = 1'b0;
      end
    end else if (w_accept) begin
      case (w_eff_ph)
        PH0: begin
          if (eol) begin
            w_push       = 1'b1;
            w_push_tdata = {8'h0, w_px};
            w_push_tlast = 1'b1;
            w_ph_nxt     = PH0;
          end else begin
            w_hold_nxt = w_px;
            w_ph_nxt   = PH1;
          end
        end
        PH1: begin
          w_push       = 1'b1;
          w_push_tdata = {w_px.b, r_hold};
          if (eol) begin
            w_tail_nxt      = {w_px.r, w_px.g};
            w_tail_pend_nxt = 1'b1;
            w_ph_nxt        = PH0;
          end else begin
            w_hold_nxt = {8'h0, w_px.r, w_px.g};
            w_ph_nxt   = PH2;
          end
        end
        PH2: begin
          w_push       = 1'b1;
          w_push_tdata = {w_px.g, w_px.b, r_hold[15:0]};
          if (eol) begin
            w_tail_nxt      = {8'h0, w_px.r};
            w_tail_pend_nxt = 1'b1;
            w_ph_nxt        = PH0;
          end else begin
            w_hold_nxt = {16'h0, w_px.r};
            w_ph_nxt   = PH3;
          end
        end
        PH3: begin
          w_push       = 1'b1;
          w_push_tdata = {w_px.r, w_px.g, w_px.b, r_hold[7:0]};
          w_push_tlast = eol;
          w_ph_nxt     = PH0;
        end
        default: ;
      endcase
    end
  end

  assign w_cnt_nxt = w_count + {1'b0, w_push} - {1'b0, w_pop};

  // At ph2 an eol needs two slots, so only accept into an empty buffer.
  assign w_in_ready_nxt = !w_tail_pend_nxt &&
                          ((w_ph_nxt == PH2) ? (w_cnt_nxt == 2'd0)
                                             : (w_cnt_nxt != SKID_FULL));

  axis_skid2 u_skid (
    .clk     (aclk),
    .rst     (areset),
    .i_push  (w_push),
    .i_tdata (w_push_tdata),
    .i_tlast (w_push_tlast),
    .i_tuser (w_sof_now),
    .o_tdata (out_stream_tdata),
    .o_tlast (out_stream_tlast),
    .o_tuser (out_stream_tuser),
    .o_valid (out_stream_tvalid),
    .i_ready (out_stream_tready),
    .o_count (w_count)
  );

  assign in_ready         = r_in_ready;
  assign out_stream_tkeep = 4'hF;

`ifdef PACKER_ALIGN_CHECK_EN
  localparam int unsigned PIX_CNT_W = $clog2(LINE_PIXELS) + 1;

  logic [PIX_CNT_W-1:0] r_pix_cnt, w_pix_idx;
  logic                 r_err_align;

  assign w_pix_idx = sof ? '0 : r_pix_cnt;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_pix_cnt   <= '0;
      r_err_align <= 1'b0;
    end else if (w_accept) begin
      if ((eol && (w_eff_ph != PH3)) ||
          (eol && (w_pix_idx != PIX_CNT_W'(LINE_PIXELS - 1))) ||
          (sof && (r_ph != PH0)))
        r_err_align <= 1'b1;
      r_pix_cnt <= eol ? '0 : w_pix_idx + 1'b1;
    end
  end

  assign err_align = r_err_align;
`endif

endmodule

// File: tb/tb_rgb_word_packer.sv
// Scoreboard bench for rgb_word_packer: a byte-stream reference model queues
// expected words, a monitor pops and compares on each output handshake.
module tb_rgb_word_packer;

  logic        aclk = 1'b0;
  logic        areset;
  logic [7:0]  r, g, b;
  logic        sof, eol, valid;
  logic        in_ready;
  logic [31:0] out_stream_tdata;
  logic [3:0]  out_stream_tkeep;
  logic        out_stream_tlast;
  logic        out_stream_tuser;
  logic        out_stream_tvalid;
  logic        out_stream_tready;
`ifdef PACKER_ALIGN_CHECK_EN
  logic        err_align;
`endif

  always #5 aclk = ~aclk;

  rgb_word_packer #(.LINE_PIXELS(640), .SKID_DEPTH(2)) dut (
    .aclk              (aclk),
    .areset            (areset),
    .r                 (r),
    .g                 (g),
    .b                 (b),
    .sof               (sof),
    .eol               (eol),
    .valid             (valid),
    .in_ready          (in_ready),
    .out_stream_tdata  (out_stream_tdata),
    .out_stream_tkeep  (out_stream_tkeep),
    .out_stream_tlast  (out_stream_tlast),
    .out_stream_tuser  (out_stream_tuser),
    .out_stream_tvalid (out_stream_tvalid),
`ifdef PACKER_ALIGN_CHECK_EN
    .err_align         (err_align),
`endif
    .out_stream_tready (out_stream_tready)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        last;
    logic        user;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  bq[$];
  logic        m_sof = 1'b0;
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned tready_mode = 0;   // 0: always ready, 1: random, 2: held low
  int unsigned n_words = 0, n_user = 0, n_last = 0;

  // Reference: pixels become a byte stream (b,g,r); every 4 bytes form a word;
  // eol flushes the remainder zero-padded; sof drops unsent bytes.
  task automatic model_pixel(input logic [23:0] px, input logic s, input logic e);
    exp_t w;
    if (s) begin
      bq.delete();
      m_sof = 1'b1;
    end
    bq.push_back(px[7:0]);
    bq.push_back(px[15:8]);
    bq.push_back(px[23:16]);
    while (bq.size() >= 4 || (e && bq.size() > 0)) begin
      w = '0;
      for (int k = 0; k < 4; k++)
        if (bq.size() > 0) w.d[8*k +: 8] = bq.pop_front();
      w.last = e && (bq.size() == 0);
      w.user = m_sof;
      m_sof  = 1'b0;
      exp_q.push_back(w);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic send_pixel(input logic [23:0] px, input logic s, input logic e);
    int unsigned waited = 0;
    {r, g, b} = px;
    sof = s; eol = e; valid = 1'b1;
    forever begin
      @(negedge aclk);
      if (in_ready) begin
        model_pixel(px, s, e);
        break;
      end
      waited++;
      if (waited > 200) begin
        checks++; errors++;
        $display("FAIL in_ready_timeout: pixel %06h not accepted in 200 cycles", px);
        break;
      end
    end
    @(posedge aclk); #1;
    valid = 1'b0; sof = 1'b0; eol = 1'b0;
  endtask

  task automatic drain(input string name);
    int unsigned waited = 0;
    while (exp_q.size() != 0 && waited < 3000) begin
      @(posedge aclk); #1;
      waited++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_drain: %0d words still expected, required 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge aclk); #1;
    @(negedge aclk);
    check({name, "_idle_tvalid"}, {31'h0, out_stream_tvalid}, 32'h0);
    @(posedge aclk); #1;
  endtask

  // Output handshake monitor and stall-stability checker.
  exp_t        e_pop;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_d;
  logic        prev_last, prev_user;

  always @(negedge aclk) begin
    if (areset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (!out_stream_tvalid || out_stream_tdata !== prev_d ||
            out_stream_tlast !== prev_last || out_stream_tuser !== prev_user) begin
          errors++;
          $display("FAIL stall_stable: got v=%0b d=%08h l=%0b u=%0b required v=1 d=%08h l=%0b u=%0b",
                   out_stream_tvalid, out_stream_tdata, out_stream_tlast, out_stream_tuser,
                   prev_d, prev_last, prev_user);
        end
      end
      if (out_stream_tvalid && out_stream_tready) begin
        n_words++;
        if (out_stream_tuser) n_user++;
        if (out_stream_tlast) n_last++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL word_unexpected: got d=%08h l=%0b u=%0b, required no word",
                   out_stream_tdata, out_stream_tlast, out_stream_tuser);
        end else begin
          e_pop = exp_q.pop_front();
          if (out_stream_tdata !== e_pop.d || out_stream_tlast !== e_pop.last ||
              out_stream_tuser !== e_pop.user || out_stream_tkeep !== 4'hF) begin
            errors++;
            $display("FAIL word: got d=%08h l=%0b u=%0b k=%h required d=%08h l=%0b u=%0b k=f",
                     out_stream_tdata, out_stream_tlast, out_stream_tuser, out_stream_tkeep,
                     e_pop.d, e_pop.last, e_pop.user);
          end
        end
      end
      stall_prev = out_stream_tvalid && !out_stream_tready;
      prev_d     = out_stream_tdata;
      prev_last  = out_stream_tlast;
      prev_user  = out_stream_tuser;
    end
  end

  initial begin
    out_stream_tready = 1'b0;
    forever begin
      @(posedge aclk); #1;
      case (tready_mode)
        0:       out_stream_tready = 1'b1;
        1:       out_stream_tready = 1'($urandom_range(0, 1));
        default: out_stream_tready = 1'b0;
      endcase
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  logic [23:0] px;
  logic        rs, re;

  initial begin
    areset = 1'b1;
    {r, g, b} = '0;
    sof = 1'b0; eol = 1'b0; valid = 1'b0;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    check("rst_tvalid",   {31'h0, out_stream_tvalid}, 32'h0);
    check("rst_tdata",    out_stream_tdata,           32'h0);
    check("rst_tlast",    {31'h0, out_stream_tlast},  32'h0);
    check("rst_tuser",    {31'h0, out_stream_tuser},  32'h0);
    check("rst_in_ready", {31'h0, in_ready},          32'h1);
`ifdef PACKER_ALIGN_CHECK_EN
    check("rst_err_align", {31'h0, err_align}, 32'h0);
`endif
    @(posedge aclk); #1;

    // Basic aligned packing plus first-word latency.
    tready_mode = 0;
    send_pixel(24'h112233, 1'b0, 1'b0);
    send_pixel(24'h445566, 1'b0, 1'b0);
    check("lat_tvalid", {31'h0, out_stream_tvalid}, 32'h1);
    check("lat_tdata",  out_stream_tdata,           32'h66112233);
    send_pixel(24'h778899, 1'b0, 1'b0);
    send_pixel(24'hAABBCC, 1'b0, 1'b0);
    drain("basic");

    // eol at ph1: two words, tail 00000405 with tlast.
    send_pixel(24'h010203, 1'b1, 1'b0);
    send_pixel(24'h040506, 1'b0, 1'b1);
    drain("eol_ph1");
`ifdef PACKER_ALIGN_CHECK_EN
    check("err_align_set", {31'h0, err_align}, 32'h1);
`endif

    // eol at ph2: normal word, then {24'h0, r} with tlast.
    send_pixel(24'h0A0B0C, 1'b1, 1'b0);
    send_pixel(24'h1A1B1C, 1'b0, 1'b0);
    send_pixel(24'h2A2B2C, 1'b0, 1'b1);
    drain("eol_ph2");

    // Reset with two words buffered and ph=2.
    tready_mode = 2;
    send_pixel(24'h313233, 1'b1, 1'b1);
    send_pixel(24'h414243, 1'b0, 1'b0);
    send_pixel(24'h515253, 1'b0, 1'b0);
    areset = 1'b1;
    exp_q.delete(); bq.delete(); m_sof = 1'b0;
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    check("mid_rst_tvalid",   {31'h0, out_stream_tvalid}, 32'h0);
    check("mid_rst_in_ready", {31'h0, in_ready},          32'h1);
    @(posedge aclk); #1;
    tready_mode = 0;
    send_pixel(24'h616263, 1'b0, 1'b0);
    send_pixel(24'h717273, 1'b0, 1'b0);
    send_pixel(24'h818283, 1'b0, 1'b0);
    send_pixel(24'h919293, 1'b0, 1'b0);
    drain("post_rst");

    // Random pixels, markers, gaps and backpressure.
    tready_mode = 1;
    for (int i = 0; i < 600; i++) begin
      px = 24'($urandom);
      rs = ($urandom_range(0, 49) == 0);
      re = ($urandom_range(0, 7) == 0);
      send_pixel(px, rs, re);
      repeat ($urandom_range(0, 2)) begin
        @(posedge aclk); #1;
      end
    end
    drain("random");

    // Three 640-pixel lines of a frame under random backpressure.
    n_words = 0; n_user = 0; n_last = 0;
    for (int i = 0; i < 3 * 640; i++)
      send_pixel(24'($urandom), (i == 0), ((i % 640) == 639));
    drain("frame");
    check("frame_words", n_words, 32'd1440);
    check("frame_tuser", n_user,  32'd1);
    check("frame_tlast", n_last,  32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
